shifter_sll_seq: RTL and testbench

//  Sequential logical-left shifter. It is the left-direction partner of the combinational

---
 rtl/shifter_sll_seq_pkg.sv | 14 +
 rtl/shifter_sll_seq_if.sv | 29 ++
 rtl/shifter_sll_seq.sv | 100 ++++++++++
 tb/tb_shifter_sll_seq.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/shifter_sll_seq_pkg.sv
// Shared types and default widths for the shifter family.
// The sequential SLL and the combinational right shifters use the same defaults.
package shifter_pkg;

   localparam int SHIFTER_N_DEF = 5;
   localparam int SHIFTER_S_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shifter_state_t;

endpackage : shifter_pkg

// File: rtl/shifter_sll_seq_if.sv
// Operand/result handshake bundle for shifter_sll_seq.
// The producer/consumer side uses the master modport and the shifter uses slave.
interface shifter_sll_seq_if
   import shifter_pkg::*;
#(
   parameter int N = SHIFTER_N_DEF,
   parameter int S = SHIFTER_S_DEF
);

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_a;
   logic [S-1:0] in_s;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_y;
   logic         busy;

   modport master (
      output in_valid, in_a, in_s, out_ready,
      input  in_ready, out_valid, out_y, busy
   );

   modport slave (
      input  in_valid, in_a, in_s, out_ready,
      output in_ready, out_valid, out_y, busy
   );

endinterface : shifter_sll_seq_if

// File: rtl/shifter_sll_seq.sv
// Sequential logical-left shifter: one bit position per clock, valid/ready on both sides.
// Shift amounts above N saturate to N so the result is zero in bounded time.
module shifter_sll_seq
   import shifter_pkg::*;
#(
   parameter int N = SHIFTER_N_DEF,
   parameter int S = SHIFTER_S_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   shifter_sll_seq_if.slave bus
);

   shifter_state_t state_q;
   logic [N-1:0]   data_q;
   logic [S-1:0]   cnt_q;
   logic           in_ready_q;
   logic           out_valid_q;
   logic           busy_q;
   logic [S-1:0]   cnt_load_d;
   logic           accept_d;

   // Clamp the requested amount to N and qualify the input handshake.
   always_comb begin
      cnt_load_d = bus.in_s;
      if (bus.in_s > S'(N)) begin
         cnt_load_d = S'(N);
      end else begin
         cnt_load_d = bus.in_s;
      end
      accept_d = bus.in_valid && in_ready_q;
   end

   // Control FSM, data register and down-counter with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= {N{1'b0}};
         cnt_q       <= {S{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  data_q     <= bus.in_a;
                  cnt_q      <= cnt_load_d;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (cnt_load_d == {S{1'b0}}) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q     <= SHIFT;
                     out_valid_q <= 1'b0;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               data_q <= {data_q[N-2:0], 1'b0};
               cnt_q  <= cnt_q - S'(1);
               // The final shift lands on the same edge that enters DONE.
               if (cnt_q == S'(1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q <= SHIFT;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end else begin
                  state_q <= DONE;
               end
            end
            default: begin
               state_q     <= IDLE;
               data_q      <= {N{1'b0}};
               cnt_q       <= {S{1'b0}};
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_y     = data_q;
   assign bus.busy      = busy_q;

endmodule : shifter_sll_seq

// File: tb/tb_shifter_sll_seq.sv
// Directed self-checking bench for shifter_sll_seq (N=5, S=3).
// Edge numbering: the edge that accepts the operand is edge 1.
module tb_shifter_sll_seq;
   import shifter_pkg::*;

   localparam int N = 5;
   localparam int S = 3;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   shifter_sll_seq_if #(.N(N), .S(S)) bus_if ();

   shifter_sll_seq #(.N(N), .S(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operand, optionally poke in_valid mid-SHIFT, hold out_ready low, then drain.
   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [S-1:0] s,
                         input logic [N-1:0] exp_y, input int exp_lat, input int hold,
                         input bit poke);
      int edges;
      bus_if.in_valid  = 1'b1;
      bus_if.in_a      = a;
      bus_if.in_s      = s;
      bus_if.out_ready = 1'b0;
      step();
      edges = 1;
      bus_if.in_valid = 1'b0;
      chk({tag, ".busy"}, 32'(bus_if.busy), 32'd1);
      chk({tag, ".in_ready_busy"}, 32'(bus_if.in_ready), 32'd0);
      while (!bus_if.out_valid && edges < 20) begin
         if (poke) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_a     = 5'b11111;
            bus_if.in_s     = 3'd0;
         end
         step();
         edges++;
         if (poke && !bus_if.out_valid) begin
            chk({tag, ".in_ready_poke"}, 32'(bus_if.in_ready), 32'd0);
         end
      end
      bus_if.in_valid = 1'b0;
      chk({tag, ".latency"}, 32'(edges), 32'(exp_lat));
      chk({tag, ".y"}, 32'(bus_if.out_y), 32'(exp_y));
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, ".hold_valid"}, 32'(bus_if.out_valid), 32'd1);
         chk({tag, ".hold_y"}, 32'(bus_if.out_y), 32'(exp_y));
      end
      bus_if.out_ready = 1'b1;
      step();
      bus_if.out_ready = 1'b0;
      chk({tag, ".drained"}, 32'(bus_if.out_valid), 32'd0);
      chk({tag, ".in_ready_back"}, 32'(bus_if.in_ready), 32'd1);
      chk({tag, ".idle_busy"}, 32'(bus_if.busy), 32'd0);
   endtask

   initial begin
      int edges;
      n_cmp = 0;
      n_err = 0;
      rst_n            = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_a      = 5'b00000;
      bus_if.in_s      = 3'd0;
      bus_if.out_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("reset.in_ready", 32'(bus_if.in_ready), 32'd1);
      chk("reset.out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("reset.out_y", 32'(bus_if.out_y), 32'd0);
      chk("reset.busy", 32'(bus_if.busy), 32'd0);

      run_op("t1_s2",     5'b10011, 3'd2, 5'b01100, 3, 0, 1'b0);
      run_op("t2_s0",     5'b10101, 3'd0, 5'b10101, 1, 0, 1'b0);
      run_op("t3_clamp",  5'b11111, 3'd7, 5'b00000, 6, 0, 1'b0);
      run_op("t3b_s5",    5'b00001, 3'd5, 5'b00000, 6, 0, 1'b0);
      run_op("t3c_s4",    5'b00001, 3'd4, 5'b10000, 5, 0, 1'b0);
      run_op("t4_stall",  5'b00111, 3'd1, 5'b01110, 2, 4, 1'b0);
      run_op("t5_poke",   5'b10011, 3'd3, 5'b11000, 4, 0, 1'b1);

      // Reset asserted mid-SHIFT aborts at once.
      bus_if.in_valid = 1'b1;
      bus_if.in_a     = 5'b10000;
      bus_if.in_s     = 3'd4;
      step();
      bus_if.in_valid = 1'b0;
      step();
      chk("t6.busy_before", 32'(bus_if.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6.out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("t6.busy", 32'(bus_if.busy), 32'd0);
      chk("t6.in_ready", 32'(bus_if.in_ready), 32'd1);
      step();
      rst_n = 1'b1;
      edges = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus_if.out_valid) edges++;
      end
      chk("t6.no_stale", 32'(edges), 32'd0);
      chk("t6.out_y", 32'(bus_if.out_y), 32'd0);

      // in_valid with out_ready in DONE: drain first, accept on the next edge.
      bus_if.in_valid = 1'b1;
      bus_if.in_a     = 5'b00001;
      bus_if.in_s     = 3'd0;
      step();
      chk("t7.first_valid", 32'(bus_if.out_valid), 32'd1);
      bus_if.in_a      = 5'b00011;
      bus_if.in_s      = 3'd2;
      bus_if.out_ready = 1'b1;
      step();
      bus_if.out_ready = 1'b0;
      chk("t7.drain_valid", 32'(bus_if.out_valid), 32'd0);
      chk("t7.drain_in_ready", 32'(bus_if.in_ready), 32'd1);
      step();
      bus_if.in_valid = 1'b0;
      chk("t7.accept_busy", 32'(bus_if.busy), 32'd1);
      edges = 1;
      while (!bus_if.out_valid && edges < 20) begin
         step();
         edges++;
      end
      chk("t7.latency", 32'(edges), 32'd3);
      chk("t7.y", 32'(bus_if.out_y), 32'(5'b01100));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_shifter_sll_seq
